// File: rtl/procyon_ieu_cdb_queue.sv
// ============================================================================
// Module      : procyon_ieu_cdb_queue
// Description : In-order result queue between the IEU execute stage and the
//               CDB, with early issue stall. Optional zero-latency bypass
//               when empty is enabled by defining PCYN_CDB_QUEUE_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module procyon_ieu_cdb_queue #(
    parameter int OPTN_DATA_WIDTH    = 32,
    parameter int OPTN_ADDR_WIDTH    = 32,
    parameter int OPTN_ROB_IDX_WIDTH = 5,
    parameter int OPTN_QUEUE_DEPTH   = 4,
    parameter int OPTN_STALL_MARGIN  = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_flush,
    input  logic                          i_ieu_valid,
    input  logic [OPTN_DATA_WIDTH-1:0]    i_ieu_data,
    input  logic [OPTN_ADDR_WIDTH-1:0]    i_ieu_addr,
    input  logic [OPTN_ROB_IDX_WIDTH-1:0] i_ieu_tag,
    input  logic                          i_ieu_redirect,
    output logic                          o_ieu_stall,
    output logic                          o_cdb_req,
    input  logic                          i_cdb_gnt,
    output logic [OPTN_DATA_WIDTH-1:0]    o_cdb_data,
    output logic [OPTN_ADDR_WIDTH-1:0]    o_cdb_addr,
    output logic [OPTN_ROB_IDX_WIDTH-1:0] o_cdb_tag,
    output logic                          o_cdb_redirect,
    output logic                          o_overflow
);

    localparam int                 c_IDX_W  = $clog2(OPTN_QUEUE_DEPTH);
    localparam int                 c_PTR_W  = c_IDX_W + 1;
    localparam logic [c_PTR_W-1:0] c_DEPTH  = c_PTR_W'(OPTN_QUEUE_DEPTH);
    localparam logic [c_PTR_W-1:0] c_MARGIN = c_PTR_W'(OPTN_STALL_MARGIN);

    typedef struct packed {
        logic [OPTN_DATA_WIDTH-1:0]    data;
        logic [OPTN_ADDR_WIDTH-1:0]    addr;
        logic [OPTN_ROB_IDX_WIDTH-1:0] tag;
        logic                          redirect;
    } entry_t;

    entry_t             r_mem_q [OPTN_QUEUE_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr_q;
    logic [c_PTR_W-1:0] r_rd_ptr_q;
    logic               r_overflow_q;

    logic [c_PTR_W-1:0] w_wr_ptr_d;
    logic [c_PTR_W-1:0] w_rd_ptr_d;
    logic               w_overflow_d;

    logic [c_PTR_W-1:0] w_count;
    logic [c_PTR_W-1:0] w_free;
    logic               w_empty;
    logic               w_full;
    logic               w_bypass;
    logic               w_pop;
    logic               w_push;
    entry_t             w_in;
    entry_t             w_head;
    entry_t             w_out;

    assign w_count = r_wr_ptr_q - r_rd_ptr_q;
    assign w_free  = c_DEPTH - w_count;
    assign w_empty = (w_count == '0);
    assign w_full  = (w_count == c_DEPTH);

    assign w_in.data     = i_ieu_data;
    assign w_in.addr     = i_ieu_addr;
    assign w_in.tag      = i_ieu_tag;
    assign w_in.redirect = i_ieu_redirect;

    assign w_head = r_mem_q[r_rd_ptr_q[c_IDX_W-1:0]];

`ifdef PCYN_CDB_QUEUE_BYPASS_EN
    assign w_bypass = w_empty & i_ieu_valid & ~i_flush;
`else
    assign w_bypass = 1'b0;
`endif

    // Only a stored entry can be popped; a granted bypass result is simply not enqueued.
    assign w_pop  = ~w_empty & i_cdb_gnt;
    assign w_push = i_ieu_valid & ~i_flush & (~w_full | w_pop) & ~(w_bypass & i_cdb_gnt);

    always_comb begin
        w_out = '0;
`ifdef PCYN_CDB_QUEUE_BYPASS_EN
        if (w_bypass) begin
            w_out = w_in;
        end else if (!w_empty) begin
            w_out = w_head;
        end
`else
        if (!w_empty) begin
            w_out = w_head;
        end
`endif
    end

    assign o_cdb_req      = ~w_empty | w_bypass;
    assign o_cdb_data     = w_out.data;
    assign o_cdb_addr     = w_out.addr;
    assign o_cdb_tag      = w_out.tag;
    assign o_cdb_redirect = w_out.redirect;
    assign o_ieu_stall    = (w_free <= c_MARGIN);
    assign o_overflow     = r_overflow_q;

    always_comb begin
        w_wr_ptr_d   = r_wr_ptr_q + c_PTR_W'(w_push);
        w_rd_ptr_d   = r_rd_ptr_q + c_PTR_W'(w_pop);
        w_overflow_d = r_overflow_q | (i_ieu_valid & ~i_flush & w_full & ~w_pop);
        // Flush drops everything in flight, including a same-cycle pop, but keeps the error flag.
        if (i_flush) begin
            w_wr_ptr_d = '0;
            w_rd_ptr_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr_q   <= '0;
            r_rd_ptr_q   <= '0;
            r_overflow_q <= 1'b0;
        end else begin
            r_wr_ptr_q   <= w_wr_ptr_d;
            r_rd_ptr_q   <= w_rd_ptr_d;
            r_overflow_q <= w_overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_q[r_wr_ptr_q[c_IDX_W-1:0]] <= w_in;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_procyon_ieu_cdb_queue.sv
// ============================================================================
// Module      : tb_procyon_ieu_cdb_queue
// Description : Directed table-driven bench for procyon_ieu_cdb_queue.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_procyon_ieu_cdb_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_flush;
    logic        i_ieu_valid;
    logic [31:0] i_ieu_data;
    logic [31:0] i_ieu_addr;
    logic [4:0]  i_ieu_tag;
    logic        i_ieu_redirect;
    logic        o_ieu_stall;
    logic        o_cdb_req;
    logic        i_cdb_gnt;
    logic [31:0] o_cdb_data;
    logic [31:0] o_cdb_addr;
    logic [4:0]  o_cdb_tag;
    logic        o_cdb_redirect;
    logic        o_overflow;

    int n_vec = 0;
    int n_err = 0;

    procyon_ieu_cdb_queue #(
        .OPTN_DATA_WIDTH   (32),
        .OPTN_ADDR_WIDTH   (32),
        .OPTN_ROB_IDX_WIDTH(5),
        .OPTN_QUEUE_DEPTH  (4),
        .OPTN_STALL_MARGIN (2)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .i_flush       (i_flush),
        .i_ieu_valid   (i_ieu_valid),
        .i_ieu_data    (i_ieu_data),
        .i_ieu_addr    (i_ieu_addr),
        .i_ieu_tag     (i_ieu_tag),
        .i_ieu_redirect(i_ieu_redirect),
        .o_ieu_stall   (o_ieu_stall),
        .o_cdb_req     (o_cdb_req),
        .i_cdb_gnt     (i_cdb_gnt),
        .o_cdb_data    (o_cdb_data),
        .o_cdb_addr    (o_cdb_addr),
        .o_cdb_tag     (o_cdb_tag),
        .o_cdb_redirect(o_cdb_redirect),
        .o_overflow    (o_overflow)
    );

    always #5 clk = ~clk;

    // Payload is derived from the tag so each row only has to name the tag.
    function automatic logic [31:0] data_of(input logic [4:0] t);
        return 32'hC0DE_0000 | {27'd0, t};
    endfunction

    function automatic logic [31:0] addr_of(input logic [4:0] t);
        return ~data_of(t);
    endfunction

    typedef struct {
        logic       flush;
        logic       valid;
        logic [4:0] tag;
        logic       redir;
        logic       gnt;
        logic       byp;
        logic       e_req;
        logic [4:0] e_tag;
        logic       e_redir;
        logic       e_stall;
        logic       e_ovf;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic fl, input logic v, input logic [4:0] t,
                                input logic rd, input logic g, input logic by,
                                input logic er, input logic [4:0] et, input logic erd,
                                input logic es, input logic eo);
        vec_t x;
        x.flush = fl; x.valid = v; x.tag = t; x.redir = rd; x.gnt = g; x.byp = by;
        x.e_req = er; x.e_tag = et; x.e_redir = erd; x.e_stall = es; x.e_ovf = eo;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic fl, input logic v, input logic [4:0] t,
                         input logic rd, input logic g);
        rst = r; i_flush = fl; i_ieu_valid = v; i_ieu_tag = t; i_ieu_redirect = rd;
        i_ieu_data = data_of(t); i_ieu_addr = addr_of(t); i_cdb_gnt = g;
    endtask

    task automatic chk_outputs(input string nm, input logic er, input logic [4:0] et,
                               input logic erd, input logic es, input logic eo);
        chk({nm, ".req"},   {31'd0, o_cdb_req},      {31'd0, er});
        chk({nm, ".tag"},   {27'd0, o_cdb_tag},      er ? {27'd0, et} : 32'd0);
        chk({nm, ".data"},  o_cdb_data,              er ? data_of(et) : 32'd0);
        chk({nm, ".addr"},  o_cdb_addr,              er ? addr_of(et) : 32'd0);
        chk({nm, ".redir"}, {31'd0, o_cdb_redirect}, {31'd0, er & erd});
        chk({nm, ".stall"}, {31'd0, o_ieu_stall},    {31'd0, es});
        chk({nm, ".ovf"},   {31'd0, o_overflow},     {31'd0, eo});
    endtask

    initial begin
        // Columns: flush valid tag redir gnt | bypass-sensitive | req tag redir stall ovf
        // In-order drain
        vecs.push_back(mk(0,1, 1,0,0, 1, 0, 0,0,0,0));
        vecs.push_back(mk(0,1, 2,0,0, 0, 1, 1,0,0,0));
        vecs.push_back(mk(0,1, 3,1,0, 0, 1, 1,0,1,0));
        vecs.push_back(mk(0,0, 0,0,1, 0, 1, 1,0,1,0));
        vecs.push_back(mk(0,0, 0,0,1, 0, 1, 2,0,1,0));
        vecs.push_back(mk(0,0, 0,0,1, 0, 1, 3,1,0,0));
        vecs.push_back(mk(0,0, 0,0,1, 0, 0, 0,0,0,0));
        // Stall threshold and fill to full
        vecs.push_back(mk(0,1, 4,0,0, 1, 0, 0,0,0,0));
        vecs.push_back(mk(0,0, 0,0,0, 0, 1, 4,0,0,0));
        vecs.push_back(mk(0,1, 5,0,0, 0, 1, 4,0,0,0));
        vecs.push_back(mk(0,0, 0,0,0, 0, 1, 4,0,1,0));
        vecs.push_back(mk(0,1, 6,0,0, 0, 1, 4,0,1,0));
        vecs.push_back(mk(0,1, 8,0,0, 0, 1, 4,0,1,0));
        vecs.push_back(mk(0,0, 0,0,0, 0, 1, 4,0,1,0));
        // Full push+pop, then push while full
        vecs.push_back(mk(0,1, 9,0,1, 0, 1, 4,0,1,0));
        vecs.push_back(mk(0,0, 0,0,0, 0, 1, 5,0,1,0));
        vecs.push_back(mk(0,1,10,0,0, 0, 1, 5,0,1,0));
        vecs.push_back(mk(0,0, 0,0,0, 0, 1, 5,0,1,1));
        vecs.push_back(mk(0,0, 0,0,1, 0, 1, 5,0,1,1));
        vecs.push_back(mk(0,0, 0,0,1, 0, 1, 6,0,1,1));
        vecs.push_back(mk(0,0, 0,0,1, 0, 1, 8,0,1,1));
        vecs.push_back(mk(0,0, 0,0,1, 0, 1, 9,0,0,1));
        vecs.push_back(mk(0,0, 0,0,1, 0, 0, 0,0,0,1));
        // Flush with same-cycle push and pop
        vecs.push_back(mk(0,1,11,0,0, 1, 0, 0,0,0,1));
        vecs.push_back(mk(0,1,12,0,0, 0, 1,11,0,0,1));
        vecs.push_back(mk(0,1,13,0,0, 0, 1,11,0,1,1));
        vecs.push_back(mk(1,1, 7,0,1, 0, 1,11,0,1,1));
        vecs.push_back(mk(0,0, 0,0,0, 0, 0, 0,0,0,1));
        vecs.push_back(mk(0,1,14,1,0, 1, 0, 0,0,0,1));
        vecs.push_back(mk(0,0, 0,0,1, 0, 1,14,1,0,1));
        vecs.push_back(mk(0,0, 0,0,0, 0, 0, 0,0,0,1));

        // Reset held for two cycles
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        #1;
        chk_outputs("reset", 0, 0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(0, vecs[i].flush, vecs[i].valid, vecs[i].tag, vecs[i].redir, vecs[i].gnt);
            #1;
`ifdef PCYN_CDB_QUEUE_BYPASS_EN
            if (!vecs[i].byp)
`endif
            chk_outputs($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_tag,
                        vecs[i].e_redir, vecs[i].e_stall, vecs[i].e_ovf);
        end

        // Reset mid-stream wins over a same-cycle flush and push
        @(negedge clk); drive(0, 0, 1, 20, 0, 0);
        @(negedge clk); drive(0, 0, 1, 21, 0, 0);
        @(negedge clk); drive(1, 1, 1, 22, 0, 0);
        @(negedge clk); drive(0, 0, 0, 0, 0, 0);
        #1;
        chk_outputs("rst_mid", 0, 0, 0, 0, 0);

`ifdef PCYN_CDB_QUEUE_BYPASS_EN
        // Zero-latency bypass with grant: result is not enqueued
        @(negedge clk);
        drive(0, 0, 1, 0, 0, 1);
        i_ieu_data = 32'h0000_DEAD;
        #1;
        chk("byp.req",  {31'd0, o_cdb_req}, 32'd1);
        chk("byp.data", o_cdb_data, 32'h0000_DEAD);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        #1;
        chk("byp.after_req", {31'd0, o_cdb_req}, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
